dram_port_arbiter: RTL and testbench

- Shares the single synchronous DRAM port between the CPU MEM stage and an external DMA/loader requester.
- CPU has fixed priority by default. A starvation counter forces a bounded DMA burst, during which the CPU pipeline is stalled.
- Sits between the MEM-stage LoadStoreUnit outputs and the DRAM macro. Its stall output feeds the HazardUnit.

---
 rtl/dram_arb_pkg.sv | 29 ++
 rtl/dram_port_arbiter_if.sv | 62 ++++++
 rtl/arb_sat_counter.sv | 50 +++++
 rtl/dram_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_dram_port_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dram_arb_pkg.sv
// ============================================================================
// Module      : dram_arb_pkg
// Description : Shared types and constants for the DRAM port arbiter.
//               Defines the arbiter FSM state, the grant encoding and the
//               "no byte strobe" constant used to mark read accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dram_arb_pkg;

    // Arbiter FSM state: normal CPU-priority mode or forced DMA burst.
    typedef enum logic {
        S_CPU   = 1'b0,
        S_BURST = 1'b1
    } arb_state_t;

    // Which requester owns the DRAM port in the current cycle.
    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } arb_grant_t;

    // Byte write strobes of a read access.
    localparam logic [3:0] WSTRB_NONE = 4'b0000;

endpackage : dram_arb_pkg

`default_nettype wire

// File: rtl/dram_port_arbiter_if.sv
// ============================================================================
// Module      : dram_port_arbiter_if
// Description : Bundle of the CPU MEM-stage port, the DMA request/response
//               port and the DRAM macro port around the arbiter.
//   slave  modport : arbiter side (services CPU/DMA requests, drives DRAM)
//   master modport : environment side (CPU, DMA engine and DRAM macro)
//   CPU : cpu_req, cpu_we[3:0], cpu_addr, cpu_wdata -> cpu_rdata, cpu_stall
//   DMA : dma_valid, dma_we[3:0], dma_addr, dma_wdata
//         -> dma_ready, dma_rvalid, dma_rdata
//   DRAM: dram_a, dram_we[3:0], dram_din -> dram_spo (registered read data)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 16
) ();

    // CPU MEM-stage port
    logic                  cpu_req;
    logic [3:0]            cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [31:0]           cpu_wdata;
    logic [31:0]           cpu_rdata;
    logic                  cpu_stall;

    // DMA / loader port
    logic                  dma_valid;
    logic                  dma_ready;
    logic [3:0]            dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [31:0]           dma_wdata;
    logic                  dma_rvalid;
    logic [31:0]           dma_rdata;

    // DRAM macro port
    logic [ADDR_WIDTH-1:0] dram_a;
    logic [3:0]            dram_we;
    logic [31:0]           dram_din;
    logic [31:0]           dram_spo;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_valid, dma_we, dma_addr, dma_wdata,
        output dma_ready, dma_rvalid, dma_rdata,
        output dram_a, dram_we, dram_din,
        input  dram_spo
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_valid, dma_we, dma_addr, dma_wdata,
        input  dma_ready, dma_rvalid, dma_rdata,
        input  dram_a, dram_we, dram_din,
        output dram_spo
    );

endinterface : dram_port_arbiter_if

`default_nettype wire

// File: rtl/arb_sat_counter.sv
// ============================================================================
// Module      : arb_sat_counter
// Description : Up-counter with synchronous clear and a terminal value MAX.
//               At MAX it either saturates (WRAP=0) or rolls over to zero
//               (WRAP=1). Clear has priority over increment.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc, clr   : count enable, synchronous clear
//   cnt        : current count
//   at_max     : cnt == MAX
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_sat_counter #(
    parameter longint unsigned MAX   = 8,
    parameter int              WIDTH = (MAX > 0) ? $clog2(MAX + 1) : 1,
    parameter bit              WRAP  = 1'b0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc,
    input  wire logic             clr,
    output logic [WIDTH-1:0]      cnt,
    output logic                  at_max
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            if (r_cnt == C_MAX) begin
                r_cnt <= WRAP ? '0 : C_MAX;
            end else begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
        end
    end

    assign cnt    = r_cnt;
    assign at_max = (r_cnt == C_MAX);

endmodule : arb_sat_counter

`default_nettype wire

// File: rtl/dram_port_arbiter.sv
// ============================================================================
// Module      : dram_port_arbiter
// Description : Shares the single synchronous DRAM port between the CPU MEM
//               stage (fixed priority) and a DMA/loader requester. A DMA
//               request refused MAX_WAIT times forces a DMA burst of up to
//               BURST_LEN beats, during which the CPU pipeline is stalled.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dram_port_arbiter_if.slave (CPU, DMA and DRAM ports)
//   perf_stall_cycles, perf_dma_beats : optional free-running counters,
//               present only when DRAM_ARB_PERF_CNT_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WAIT   = 8,
    parameter int BURST_LEN  = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    dram_port_arbiter_if.slave   bus
`ifdef DRAM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]          perf_stall_cycles,
    output logic [31:0]          perf_dma_beats
`endif
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    // A one-beat burst never leaves S_CPU, but beat_cnt still needs a bit.
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam bit C_HAS_BURST = (BURST_LEN > 1);
    // The entry beat is taken in S_CPU, so the burst ends on the beat seen
    // with beat_cnt == BURST_LEN-2.
    localparam logic [BEAT_W-1:0] C_BEAT_LAST =
        (BURST_LEN > 1) ? BEAT_W'(BURST_LEN - 2) : '0;

    arb_state_t          r_state;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic                r_dma_rvalid;

    logic [WAIT_W-1:0]   w_wait_cnt;
    logic                w_wait_at_max;
    logic                w_force;
    arb_grant_t          w_gnt;
    logic                w_dma_ready;
    logic                w_hs;
    logic                w_cpu_stall;
    logic [ADDR_WIDTH-1:0] w_dram_a;
    logic [3:0]          w_dram_we;
    logic [31:0]         w_dram_din;

    // ------------------------------------------------------------------
    // Grant: combinational from state, requests and the wait counter.
    // ------------------------------------------------------------------
    always_comb begin
        w_force = (r_state == S_CPU) && w_wait_at_max && bus.dma_valid;
        w_gnt   = GNT_DMA;
        if (r_state == S_CPU && !w_force && bus.cpu_req) begin
            w_gnt = GNT_CPU;
        end
    end

    assign w_dma_ready = (w_gnt == GNT_DMA);
    assign w_hs        = bus.dma_valid && w_dma_ready;
    // Whenever DMA owns the port a waiting CPU access cannot proceed.
    assign w_cpu_stall = bus.cpu_req && (w_gnt == GNT_DMA);

    // ------------------------------------------------------------------
    // Starvation counter: counts refused DMA cycles, cleared by any DMA
    // handshake (which includes the forced entry beat).
    // ------------------------------------------------------------------
    arb_sat_counter #(
        .MAX   (MAX_WAIT),
        .WIDTH (WAIT_W),
        .WRAP  (1'b0)
    ) u_wait_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (bus.dma_valid && !w_dma_ready),
        .clr    (w_hs),
        .cnt    (w_wait_cnt),
        .at_max (w_wait_at_max)
    );

    // ------------------------------------------------------------------
    // Port mux. An idle DMA grant parks the address on dma_addr but never
    // writes.
    // ------------------------------------------------------------------
    always_comb begin
        w_dram_a   = bus.dma_addr;
        w_dram_we  = WSTRB_NONE;
        w_dram_din = '0;
        if (w_gnt == GNT_CPU) begin
            w_dram_a   = bus.cpu_addr;
            w_dram_we  = bus.cpu_we;
            w_dram_din = bus.cpu_wdata;
        end else if (bus.dma_valid) begin
            w_dram_we  = bus.dma_we;
            w_dram_din = bus.dma_wdata;
        end
    end

    // ------------------------------------------------------------------
    // FSM with burst beat counter and registered DMA read-valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_CPU;
            r_beat_cnt   <= '0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_dma_rvalid <= w_hs && (bus.dma_we == WSTRB_NONE);
            case (r_state)
                S_CPU: begin
                    if (w_force && C_HAS_BURST) begin
                        r_state    <= S_BURST;
                        r_beat_cnt <= '0;
                    end
                end
                S_BURST: begin
                    if (!bus.dma_valid || (r_beat_cnt == C_BEAT_LAST)) begin
                        r_state    <= S_CPU;
                        r_beat_cnt <= '0;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                    end
                end
                default: begin
                    r_state    <= S_CPU;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.dram_a     = w_dram_a;
    assign bus.dram_we    = w_dram_we;
    assign bus.dram_din   = w_dram_din;
    assign bus.dma_ready  = w_dma_ready;
    assign bus.cpu_stall  = w_cpu_stall;
    assign bus.dma_rvalid = r_dma_rvalid;
    assign bus.dma_rdata  = bus.dram_spo;
    assign bus.cpu_rdata  = bus.dram_spo;

    // ------------------------------------------------------------------
    // Optional performance counters (free-running, wrap at 2^32).
    // ------------------------------------------------------------------
`ifdef DRAM_ARB_PERF_CNT_EN
    logic w_unused_stall_wrap;
    logic w_unused_beats_wrap;

    arb_sat_counter #(
        .MAX   (64'hFFFF_FFFF),
        .WIDTH (32),
        .WRAP  (1'b1)
    ) u_perf_stall (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (w_cpu_stall),
        .clr    (1'b0),
        .cnt    (perf_stall_cycles),
        .at_max (w_unused_stall_wrap)
    );

    arb_sat_counter #(
        .MAX   (64'hFFFF_FFFF),
        .WIDTH (32),
        .WRAP  (1'b1)
    ) u_perf_beats (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (w_hs),
        .clr    (1'b0),
        .cnt    (perf_dma_beats),
        .at_max (w_unused_beats_wrap)
    );
`endif

    // ------------------------------------------------------------------
    // DMA protocol: a refused request keeps its payload stable.
    // ------------------------------------------------------------------
    a_dma_hold : assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.dma_valid && !w_dma_ready) |=>
            (!bus.dma_valid || ($stable(bus.dma_we) && $stable(bus.dma_addr)
                                && $stable(bus.dma_wdata)))
    );

    a_wait_bound : assert property (
        @(posedge clk) disable iff (!rst_n)
        w_wait_cnt <= WAIT_W'(MAX_WAIT)
    );

endmodule : dram_port_arbiter

`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
// ============================================================================
// Module      : tb_dram_port_arbiter
// Description : Directed self-checking bench for dram_port_arbiter
//               (MAX_WAIT=8, BURST_LEN=4) with a small registered DRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_port_arbiter;
    import dram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    dram_port_arbiter_if #(.ADDR_WIDTH(16)) bus ();

`ifdef DRAM_ARB_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_dma_beats;
`endif

    dram_port_arbiter #(
        .ADDR_WIDTH (16),
        .MAX_WAIT   (8),
        .BURST_LEN  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DRAM_ARB_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_dma_beats    (perf_dma_beats)
`endif
    );

    // Registered-output DRAM model (read-before-write, byte strobes).
    logic [31:0] mem [0:255];
    logic [31:0] spo_q = 32'h0;
    always @(posedge clk) begin
        spo_q <= mem[bus.dram_a[7:0]];
        for (int b = 0; b < 4; b++) begin
            if (bus.dram_we[b]) mem[bus.dram_a[7:0]][8*b +: 8] <= bus.dram_din[8*b +: 8];
        end
    end
    assign bus.dram_spo = spo_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 4'h0;
        bus.cpu_addr  = 16'h0;
        bus.cpu_wdata = 32'h0;
        bus.dma_valid = 1'b0;
        bus.dma_we    = 4'h0;
        bus.dma_addr  = 16'h0;
        bus.dma_wdata = 32'h0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // CPU reads 0x0030 continuously while DMA reads 0x0040.
    task automatic contend();
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 16'h0030;
        bus.dma_valid = 1'b1;
        bus.dma_we    = 4'h0;
        bus.dma_addr  = 16'h0040;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h1234_5678;

        // ---------------- reset values ----------------
        idle();
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst_stall",  bus.cpu_stall, 0);
        chk("rst_ready",  bus.dma_ready, 1);
        chk("rst_we",     bus.dram_we, 0);
        chk("rst_rvalid", bus.dma_rvalid, 0);
        chk("rst_wait",   dut.w_wait_cnt, 0);
        chk("rst_state",  dut.r_state, S_CPU);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- S1: DMA read with idle CPU ----------------
        bus.dma_valid = 1'b1;
        bus.dma_we    = 4'h0;
        bus.dma_addr  = 16'h0010;
        #1;
        chk("s1_ready",  bus.dma_ready, 1);
        chk("s1_stall",  bus.cpu_stall, 0);
        chk("s1_dram_a", bus.dram_a, 16'h0010);
        chk("s1_dram_we", bus.dram_we, 0);
        @(negedge clk);
        idle();
        #1;
        chk("s1_rvalid", bus.dma_rvalid, 1);
        chk("s1_rdata",  bus.dma_rdata, 32'h1234_5678);
        chk("s1_cpu_rdata", bus.cpu_rdata, 32'h1234_5678);
        @(negedge clk); #1;
        chk("s1_rvalid_clr", bus.dma_rvalid, 0);

        // ---------------- S2: starvation -> full 4-beat burst ----------------
        do_reset();
        contend();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("s2_refuse_ready", bus.dma_ready, 0);
            chk("s2_refuse_stall", bus.cpu_stall, 0);
            chk("s2_refuse_a",     bus.dram_a, 16'h0030);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s2_burst_ready", bus.dma_ready, 1);
            chk("s2_burst_stall", bus.cpu_stall, 1);
            chk("s2_burst_a",     bus.dram_a, 16'h0040);
            @(negedge clk);
        end
        #1;
        chk("s2_exit_ready", bus.dma_ready, 0);
        chk("s2_exit_stall", bus.cpu_stall, 0);
        chk("s2_exit_state", dut.r_state, S_CPU);
        chk("s2_exit_wait",  dut.w_wait_cnt, 0);
        chk("s2_exit_rvalid", bus.dma_rvalid, 1);
`ifdef DRAM_ARB_PERF_CNT_EN
        chk("s2_perf_stall", perf_stall_cycles, 4);
        chk("s2_perf_beats", perf_dma_beats, 4);
`endif

        // ---------------- S3: DMA drops after 2nd forced beat ----------------
        do_reset();
        contend();
        repeat (8) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("s3_burst_stall", bus.cpu_stall, 1);
            @(negedge clk);
        end
        bus.dma_valid = 1'b0;
        #1;
        chk("s3_drop_ready", bus.dma_ready, 1);
        chk("s3_drop_we",    bus.dram_we, 0);
        @(negedge clk); #1;
        chk("s3_exit_state", dut.r_state, S_CPU);
        chk("s3_exit_stall", bus.cpu_stall, 0);
        chk("s3_exit_ready", bus.dma_ready, 0);
        chk("s3_exit_a",     bus.dram_a, 16'h0030);

        // ---------------- S4: simultaneous writes to 0x0020 ----------------
        do_reset();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 4'b0011;
        bus.cpu_addr  = 16'h0020;
        bus.cpu_wdata = 32'hAABB_CCDD;
        bus.dma_valid = 1'b1;
        bus.dma_we    = 4'b1111;
        bus.dma_addr  = 16'h0020;
        bus.dma_wdata = 32'h1122_3344;
        #1;
        chk("s4_cpu_we",    bus.dram_we, 4'b0011);
        chk("s4_cpu_din",   bus.dram_din, 32'hAABB_CCDD);
        chk("s4_cpu_ready", bus.dma_ready, 0);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 4'h0;
        #1;
        chk("s4_dma_ready", bus.dma_ready, 1);
        chk("s4_dma_we",    bus.dram_we, 4'b1111);
        chk("s4_dma_din",   bus.dram_din, 32'h1122_3344);
        @(negedge clk);
        bus.dma_we = 4'h0;
        #1;
        chk("s4_rd_ready", bus.dma_ready, 1);
        chk("s4_rd_we",    bus.dram_we, 0);
        @(negedge clk);
        idle();
        #1;
        chk("s4_rvalid", bus.dma_rvalid, 1);
        chk("s4_final",  bus.dma_rdata, 32'h1122_3344);

        // ---------------- S5: reset during 3rd burst beat ----------------
        do_reset();
        contend();
        repeat (10) @(negedge clk);
        #1;
        chk("s5_beat3_ready",  bus.dma_ready, 1);
        chk("s5_beat3_rvalid", bus.dma_rvalid, 1);
        chk("s5_beat3_state",  dut.r_state, S_BURST);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_state",  dut.r_state, S_CPU);
        chk("s5_rst_rvalid", bus.dma_rvalid, 0);
        chk("s5_rst_wait",   dut.w_wait_cnt, 0);
        chk("s5_rst_beat",   dut.r_beat_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("s5_rel_ready", bus.dma_ready, 0);
        chk("s5_rel_stall", bus.cpu_stall, 0);
        chk("s5_rel_a",     bus.dram_a, 16'h0030);

        idle();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_dram_port_arbiter

`default_nettype wire
